// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller sharing one BCD-to-7-segment decoder across NUM_DIGITS common-anode digits
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   en          : display enable, 0 forces all anodes off
//   load        : strobe capturing digits_in into the shadow register
//   digits_in   : packed 4-bit codes, digit 0 in the low nibble
//   digit_code  : code of the selected digit, fed to the decoder
//   an_n        : active-low anode enables, at most one low
//   digit_idx   : index of the selected digit
//   frame_tick  : pulse on the last lit cycle of the highest digit
//   Define SEG7_LZB_EN to blank leading zero digits.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int IDXW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [IDXW-1:0]         digit_idx,
  output logic                    frame_tick
);
  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? ((REFRESH_DIV > 2) ? REFRESH_DIV : 2)
                                                     : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
  localparam int CW = $clog2(CMAX);
  typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;
  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [3:0]              code_q, code_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;
  logic [4*NUM_DIGITS-1:0] digit_q, src;
  logic [(1<<IDXW)-1:0]    keep;
  logic                    acc;
  always_comb begin
    // a load on the slot-entry edge is already visible in the new slot
    src     = load ? digits_in : digit_q;
    keep    = '1;
    acc     = 1'b0;
`ifdef SEG7_LZB_EN
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      acc     = acc | (|src[4*i +: 4]);
      keep[i] = acc;
    end
`endif
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    code_d  = code_q;
    if (!en) begin
      state_d = OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == OFF) begin
      state_d = (BLANK_CYCLES == 0) ? SHOW : BLANK;
      cnt_d   = '0;
      code_d  = src[3:0];
    end else if (state_q == BLANK && int'(cnt_q) + 1 >= BLANK_CYCLES) begin
      state_d = SHOW;
      cnt_d   = '0;
      code_d  = src[{idx_q, 2'b00} +: 4];
    end else if (state_q == SHOW && int'(cnt_q) + 1 >= REFRESH_DIV) begin
      idx_d   = (idx_q == IDXW'(NUM_DIGITS - 1)) ? '0 : idx_q + IDXW'(1);
      state_d = (BLANK_CYCLES == 0) ? SHOW : BLANK;
      cnt_d   = '0;
      code_d  = src[{idx_d, 2'b00} +: 4];
    end
    // outputs are computed from the next state so they can be registered
    an_d   = (state_d == SHOW && keep[idx_d]) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    tick_d = state_d == SHOW && idx_d == IDXW'(NUM_DIGITS - 1) && int'(cnt_d) + 1 >= REFRESH_DIV;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      an_q    <= '1;
      tick_q  <= 1'b0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
      digit_q <= src;
    end
  end
  assign digit_code = code_q;
  assign an_n       = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: scoreboard bench for seg7_scan_ctrl (4 digits, 4-cycle show, 1-cycle blank, plus a zero-blank instance)
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  digit_code, an_n, code_z, an_z;
  logic [1:0]  digit_idx, idx_z;
  logic        frame_tick, tick_z;
  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .digit_code(digit_code), .an_n(an_n), .digit_idx(digit_idx), .frame_tick(frame_tick));
  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .digit_code(code_z), .an_n(an_z), .digit_idx(idx_z), .frame_tick(tick_z));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] an;
    logic [3:0] code;
    logic       cv;
    logic [1:0] idx;
    logic       tk;
  } exp_t;
  exp_t        sb[$];
  exp_t        e;
  int          tests = 0, fails = 0;
  int          t = 0, zt = 0, nticks = 0;
  bit          off = 1'b0, zoff = 1'b0, zv = 1'b0;
  logic [15:0] sh = '0;
  logic [3:0]  cur_code = '0;
  function automatic bit lit_m(int d, logic [15:0] s);
`ifdef SEG7_LZB_EN
    return d == 0 || (s >> (4 * d)) != 16'h0;
`else
    return 1'b1;
`endif
  endfunction
  task automatic step(input logic e_i, input logic ld, input logic [15:0] d);
    exp_t x;
    int   dg;
    en = e_i; load = ld; digits_in = d;
    if (ld) sh = d;
    x = '{an: 4'hF, default: '0};
    if (e_i) begin
      if (off) begin off = 1'b0; t = 0; end else t++;
      dg = (t / 5) % 4;
      if (t % 5 == 1) cur_code = sh[4*dg +: 4];
      x.idx  = 2'(dg);
      x.code = cur_code;
      x.cv   = t % 5 != 0;
      x.an   = (t % 5 != 0 && lit_m(dg, sh)) ? ~(4'b1 << dg) : 4'hF;
      x.tk   = t % 20 == 19;
    end else begin
      off = 1'b1;
      t   = 0;
    end
    sb.push_back(x);
    if (!e_i) zoff = 1'b1;
    else if (zoff) begin zoff = 1'b0; zt = 0; zv = 1'b1; end
    else zt++;
    @(posedge clk); #1;
    load = 1'b0;
  endtask
  task automatic model_reset();
    sb.delete();
    t = 0; off = 1'b0; sh = '0; cur_code = '0; zoff = 1'b0; zv = 1'b0;
  endtask
  task automatic test_reset();
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({an_n, digit_code, digit_idx, frame_tick} !== {4'hF, 4'h0, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset an=%b code=%h idx=%0d tick=%b required 1111/0/0/0", an_n, digit_code, digit_idx, frame_tick);
    end
    tests++;
    if ({an_z, code_z, idx_z, tick_z} !== {4'hF, 4'h0, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_z an=%b code=%h idx=%0d tick=%b required 1111/0/0/0", an_z, code_z, idx_z, tick_z);
    end
    #4 rst_n = 1'b1;
    model_reset();
  endtask
  task automatic test_scan();
    for (int i = 0; i < 44; i++) begin
      step(1'b1, i == 0, 16'h4321);
      e = sb.pop_front(); tests++;
      if (frame_tick === 1'b1) nticks++;
      if ({an_n, digit_idx, frame_tick} !== {e.an, e.idx, e.tk} || (e.cv && digit_code !== e.code)) begin
        fails++;
        $display("FAIL scan t=%0d an=%b idx=%0d tick=%b code=%h required an=%b idx=%0d tick=%b code=%h",
                 t, an_n, digit_idx, frame_tick, digit_code, e.an, e.idx, e.tk, e.code);
      end
    end
    tests++;
    if (nticks !== 2) begin
      fails++;
      $display("FAIL frame_tick_count got %0d required 2", nticks);
    end
  endtask
  task automatic test_midload();
    for (int i = 0; i < 45; i++) begin
      step(1'b1, t % 20 == 7 && i < 25, 16'h7777);
      e = sb.pop_front(); tests++;
      if ({an_n, digit_idx, frame_tick} !== {e.an, e.idx, e.tk} || (e.cv && digit_code !== e.code)) begin
        fails++;
        $display("FAIL midload t=%0d an=%b idx=%0d tick=%b code=%h required an=%b idx=%0d tick=%b code=%h",
                 t, an_n, digit_idx, frame_tick, digit_code, e.an, e.idx, e.tk, e.code);
      end
    end
  endtask
  task automatic test_en_drop();
    for (int i = 0; i < 14; i++) begin
      step(!(i >= 5 && i < 7 && t % 5 == 2 || i == 6 && off), 1'b0, 16'h0);
      e = sb.pop_front(); tests++;
      if ({an_n, digit_idx, frame_tick} !== {e.an, e.idx, e.tk} || (e.cv && digit_code !== e.code)) begin
        fails++;
        $display("FAIL en_drop t=%0d en=%b an=%b idx=%0d code=%h required an=%b idx=%0d code=%h",
                 t, en, an_n, digit_idx, digit_code, e.an, e.idx, e.code);
      end
    end
  endtask
  task automatic test_async_reset();
    repeat (7) begin step(1'b1, 1'b0, 16'h0); e = sb.pop_front(); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({an_n, digit_code, digit_idx, frame_tick} !== {4'hF, 4'h0, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset an=%b code=%h idx=%0d tick=%b required 1111/0/0/0", an_n, digit_code, digit_idx, frame_tick);
    end
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, i == 0, 16'h8A9F);
      e = sb.pop_front(); tests++;
      if ({an_n, digit_idx, frame_tick} !== {e.an, e.idx, e.tk} || (e.cv && digit_code !== e.code)) begin
        fails++;
        $display("FAIL after_reset t=%0d an=%b idx=%0d code=%h required an=%b idx=%0d code=%h",
                 t, an_n, digit_idx, digit_code, e.an, e.idx, e.code);
      end
    end
  endtask
  task automatic test_lzb();
    for (int i = 0; i < 30; i++) begin
      step(1'b1, i == 0, 16'h0050);
      e = sb.pop_front(); tests++;
      if ({an_n, digit_idx, frame_tick} !== {e.an, e.idx, e.tk} || (e.cv && digit_code !== e.code)) begin
        fails++;
        $display("FAIL lzb t=%0d an=%b idx=%0d code=%h required an=%b idx=%0d code=%h",
                 t, an_n, digit_idx, digit_code, e.an, e.idx, e.code);
      end
    end
  endtask
  task automatic test_blank0();
    step(1'b0, 1'b1, 16'h4321); e = sb.pop_front();
    step(1'b0, 1'b0, 16'h0);    e = sb.pop_front();
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 16'h0);
      e = sb.pop_front(); tests++;
      if ({an_n, digit_idx, frame_tick} !== {e.an, e.idx, e.tk} || (e.cv && digit_code !== e.code)) begin
        fails++;
        $display("FAIL blank1_run t=%0d an=%b idx=%0d code=%h required an=%b idx=%0d code=%h",
                 t, an_n, digit_idx, digit_code, e.an, e.idx, e.code);
      end
      tests++;
      if (!zv || an_z !== ~(4'b1 << ((zt / 4) % 4)) || idx_z !== 2'((zt / 4) % 4) ||
          code_z !== sh[4*((zt/4)%4) +: 4] || tick_z !== (zt % 16 == 15)) begin
        fails++;
        $display("FAIL blank0 zt=%0d an=%b idx=%0d code=%h tick=%b required an=%b idx=%0d code=%h tick=%b",
                 zt, an_z, idx_z, code_z, tick_z, ~(4'b1 << ((zt / 4) % 4)), (zt / 4) % 4,
                 sh[4*((zt/4)%4) +: 4], zt % 16 == 15);
      end
      tests++;
      if ($countones(~an_z) > 1 || $countones(~an_n) > 1) begin
        fails++;
        $display("FAIL onehot an_z=%b an=%b required at most one low", an_z, an_n);
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_scan();
    test_midload();
    test_en_drop();
    test_async_reset();
    test_lzb();
    test_blank0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
